// File: rtl/mcd_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
package mcd_arb_pkg;

    localparam int unsigned DELAY_DEF = 2;
    localparam int unsigned ADDR_W    = 23;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned NPORT     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PORT_A = 2'd0,
        PORT_B = 2'd1,
        PORT_C = 2'd2
    } port_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              oe;
        logic              we_lo;
        logic              we_hi;
    } mem_req_t;

    // Round-robin pick: search begins at the port after the last one granted.
    function automatic port_t rr_pick(input port_t last, input logic [NPORT-1:0] pend);
        port_t pick;
        case (last)
            PORT_A:  pick = pend[1] ? PORT_B : (pend[2] ? PORT_C : PORT_A);
            PORT_B:  pick = pend[2] ? PORT_C : (pend[0] ? PORT_A : PORT_B);
            default: pick = pend[0] ? PORT_A : (pend[1] ? PORT_B : PORT_C);
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mcd_req_latch.sv
// Rising-edge detector plus pending latch for one requester.
// pend also reflects an edge in the current cycle so the arbiter can grant it at once.
module mcd_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic grant,
    output logic pend
);

    logic prev_q;
    logic armed_q;
    logic pend_q;
    logic edge_c;

    // armed_q stays low until the request has been seen low after reset,
    // so a level held through reset never counts as a fresh edge.
    assign edge_c = req & ~prev_q & armed_q;
    assign pend   = pend_q | edge_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            prev_q  <= req;
            armed_q <= armed_q | ~req;
            pend_q  <= grant ? 1'b0 : (pend_q | edge_c);
        end
    end

endmodule

// File: rtl/mcd_mem_arb3.sv
// Three-port round-robin arbiter onto a single asynchronous-style memory,
// holding strobes for DELAY+1 cycles followed by a one-cycle recovery gap.
module mcd_mem_arb3
    import mcd_arb_pkg::*;
#(
    parameter int unsigned DELAY = DELAY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oe_a,
    input  logic              we_lo_a,
    input  logic              we_hi_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              ack_a,
    input  logic              oe_b,
    input  logic              we_lo_b,
    input  logic              we_hi_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              ack_b,
    input  logic              oe_c,
    input  logic              we_lo_c,
    input  logic              we_hi_c,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [DATA_W-1:0] din_c,
    output logic [DATA_W-1:0] dout_c,
    output logic              ack_c,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic              oe,
    output logic              we_lo,
    output logic              we_hi
);

    mem_req_t [NPORT-1:0] req_in;
    logic     [NPORT-1:0] req_lvl;
    logic     [NPORT-1:0] pend_c;
    logic     [NPORT-1:0] grant_c;
    port_t                sel_c;

    state_t                          state_q, state_d;
    logic     [CNT_W-1:0]            cnt_q, cnt_d;
    port_t                           last_q, last_d;
    mem_req_t                        mem_q, mem_d;
    logic     [NPORT-1:0][DATA_W-1:0] dout_q, dout_d;
    logic     [NPORT-1:0]            ack_q, ack_d;

    assign req_in[0] = {addr_a, din_a, oe_a, we_lo_a, we_hi_a};
    assign req_in[1] = {addr_b, din_b, oe_b, we_lo_b, we_hi_b};
    assign req_in[2] = {addr_c, din_c, oe_c, we_lo_c, we_hi_c};
    assign req_lvl   = {oe_c | we_lo_c | we_hi_c,
                        oe_b | we_lo_b | we_hi_b,
                        oe_a | we_lo_a | we_hi_a};

    for (genvar i = 0; i < NPORT; i++) begin : g_req
        mcd_req_latch u_req_latch (
            .clk   (clk),
            .rst   (rst),
            .req   (req_lvl[i]),
            .grant (grant_c[i]),
            .pend  (pend_c[i])
        );
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        mem_d   = mem_q;
        dout_d  = dout_q;
        ack_d   = '0;
        grant_c = '0;
        sel_c   = rr_pick(last_q, pend_c);
        case (state_q)
            ST_IDLE: begin
                if (|pend_c) begin
                    grant_c[sel_c] = 1'b1;
                    mem_d          = req_in[sel_c];
                    cnt_d          = CNT_W'(DELAY);
                    last_d         = sel_c;
                    state_d        = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_d.oe    = 1'b0;
                    mem_d.we_lo = 1'b0;
                    mem_d.we_hi = 1'b0;
                    if (mem_q.oe) begin
                        dout_d[last_q] = dout;
                    end
                    ack_d[last_q] = 1'b1;
                    state_d       = ST_RECOVER;
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= PORT_C;
            mem_q   <= '0;
            dout_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            mem_q   <= mem_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
        end
    end

    assign addr   = mem_q.addr;
    assign din    = mem_q.din;
    assign oe     = mem_q.oe;
    assign we_lo  = mem_q.we_lo;
    assign we_hi  = mem_q.we_hi;
    assign dout_a = dout_q[0];
    assign dout_b = dout_q[1];
    assign dout_c = dout_q[2];
    assign ack_a  = ack_q[0];
    assign ack_b  = ack_q[1];
    assign ack_c  = ack_q[2];

endmodule

// File: tb/tb_mcd_mem_arb3.sv
// Scoreboard bench for mcd_mem_arb3 with DELAY=2 and a fixed-pattern memory model.
module tb_mcd_mem_arb3;

    localparam int unsigned DLY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        oe_a = 1'b0, we_lo_a = 1'b0, we_hi_a = 1'b0;
    logic        oe_b = 1'b0, we_lo_b = 1'b0, we_hi_b = 1'b0;
    logic        oe_c = 1'b0, we_lo_c = 1'b0, we_hi_c = 1'b0;
    logic [22:0] addr_a = '0, addr_b = '0, addr_c = '0;
    logic [15:0] din_a = '0, din_b = '0, din_c = '0;
    logic [15:0] dout_a, dout_b, dout_c;
    logic        ack_a, ack_b, ack_c;
    logic [22:0] addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        oe, we_lo, we_hi;

    typedef struct {
        int          port;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   oe_cnt  = 0;
    int   wlo_cnt = 0;
    int   run_oe  = 0;
    int   run_wlo = 0;
    int   run_whi = 0;

    mcd_mem_arb3 #(.DELAY(DLY)) dut (
        .clk(clk), .rst(rst),
        .oe_a(oe_a), .we_lo_a(we_lo_a), .we_hi_a(we_hi_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a), .ack_a(ack_a),
        .oe_b(oe_b), .we_lo_b(we_lo_b), .we_hi_b(we_hi_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b), .ack_b(ack_b),
        .oe_c(oe_c), .we_lo_c(we_lo_c), .we_hi_c(we_hi_c), .addr_c(addr_c), .din_c(din_c),
        .dout_c(dout_c), .ack_c(ack_c),
        .addr(addr), .din(din), .dout(dout), .oe(oe), .we_lo(we_lo), .we_hi(we_hi)
    );

    always #5 clk = ~clk;

    // Memory model: one fixed location, everything else a simple address pattern.
    always_comb dout = (addr == 23'h000100) ? 16'h1234 : (addr[15:0] ^ 16'h5A5A);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] dout_of(input int p);
        case (p)
            0:       return dout_a;
            1:       return dout_b;
            default: return dout_c;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every ack and checks strobe lengths.
    always @(negedge clk) begin
        logic [2:0] ack_v;
        exp_t e;
        ack_v = {ack_c, ack_b, ack_a};
        for (int p = 0; p < 3; p++) begin
            if (ack_v[p]) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(p), 32'hFF);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", 32'(p), 32'(e.port));
                    check("ack_data", 32'(dout_of(p)), 32'(e.data));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
        if (rst) begin
            run_oe = 0; run_wlo = 0; run_whi = 0;
        end else begin
            if (oe) begin oe_cnt++; run_oe++; end
            else if (run_oe != 0) begin check("oe_len", 32'(run_oe), 32'(DLY + 1)); run_oe = 0; end
            if (we_lo) begin wlo_cnt++; run_wlo++; end
            else if (run_wlo != 0) begin check("we_lo_len", 32'(run_wlo), 32'(DLY + 1)); run_wlo = 0; end
            if (we_hi) run_whi++;
            else if (run_whi != 0) begin check("we_hi_len", 32'(run_whi), 32'(DLY + 1)); run_whi = 0; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        while (sb.size() != 0 && k < max_cyc) begin
            tick(1);
            k++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic push(input int port, input logic [15:0] data, input int at);
        exp_t e;
        e.port = port; e.data = data; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic check_reset_state();
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_we", 32'({we_lo, we_hi}), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        check("rst_acks", 32'({ack_a, ack_b, ack_c}), 32'd0);
        check("rst_douts", 32'(dout_a | dout_b | dout_c), 32'd0);
    endtask

    initial begin
        int p;
        int snap;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int snap;
        tick(2);
        check_reset_state();
        rst = 1'b0;
        tick(2);

        // Single read from port a
        p = cyc;
        addr_a = 23'h000100; oe_a = 1'b1;
        push(0, 16'h1234, p + 4);
        tick(2);
        check("rd_oe", 32'(oe), 32'd1);
        check("rd_addr", 32'(addr), 32'h100);
        tick(6);
        drain(10);
        check("rd_dout_a", 32'(dout_a), 32'h1234);
        oe_a = 1'b0;
        tick(2);

        // Reset clears captured data and restores last-granted = c
        rst = 1'b1;
        #1;
        check_reset_state();
        tick(2);
        rst = 1'b0;
        tick(2);

        // Simultaneous edges: a, b, c served in order
        p = cyc;
        addr_a = 23'h10; addr_b = 23'h20; addr_c = 23'h30;
        oe_a = 1'b1; oe_b = 1'b1; oe_c = 1'b1;
        push(0, 16'h5A4A, p + 4);
        push(1, 16'h5A7A, p + 9);
        push(2, 16'h5A6A, p + 14);
        tick(16);
        drain(10);
        check("rr_dout_a", 32'(dout_a), 32'h5A4A);
        check("rr_dout_b", 32'(dout_b), 32'h5A7A);
        check("rr_dout_c", 32'(dout_c), 32'h5A6A);
        oe_a = 1'b0; oe_b = 1'b0; oe_c = 1'b0;
        tick(2);

        // High-byte write from port b; dout_b must hold
        p = cyc;
        snap = wlo_cnt;
        addr_b = 23'h40; din_b = 16'hAB00; we_hi_b = 1'b1;
        push(1, 16'h5A7A, p + 4);
        tick(2);
        check("wr_we_hi", 32'(we_hi), 32'd1);
        check("wr_oe", 32'(oe), 32'd0);
        check("wr_din", 32'(din), 32'hAB00);
        check("wr_addr", 32'(addr), 32'h40);
        tick(6);
        drain(10);
        check("wr_we_lo_never", 32'(wlo_cnt - snap), 32'd0);
        check("wr_dout_b_hold", 32'(dout_b), 32'h5A7A);
        check("wr_dout_a_hold", 32'(dout_a), 32'h5A4A);
        we_hi_b = 1'b0;
        tick(2);

        // Port a re-requests during its own access while c pends: c goes first
        p = cyc;
        addr_a = 23'h50; oe_a = 1'b1;
        push(0, 16'h5A0A, p + 4);
        tick(1);
        addr_c = 23'h60; oe_c = 1'b1;
        push(2, 16'h5A3A, p + 9);
        tick(1);
        oe_a = 1'b0;
        tick(1);
        oe_a = 1'b1;
        push(0, 16'h5A0A, p + 14);
        tick(16);
        drain(10);
        oe_a = 1'b0; oe_c = 1'b0;
        tick(15);

        // Reset in the second access cycle with oe_a still high
        p = cyc;
        addr_a = 23'h70; oe_a = 1'b1;
        tick(2);
        check("abort_oe_before", 32'(oe), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_oe", 32'(oe), 32'd0);
        check("abort_addr", 32'(addr), 32'd0);
        check("abort_ack", 32'(ack_a), 32'd0);
        tick(2);
        rst = 1'b0;
        snap = oe_cnt;
        tick(10);
        check("no_access_held_level", 32'(oe_cnt - snap), 32'd0);
        oe_a = 1'b0;
        tick(2);
        p = cyc;
        oe_a = 1'b1;
        push(0, 16'h5A2A, p + 4);
        tick(8);
        drain(10);
        check("post_rst_dout_a", 32'(dout_a), 32'h5A2A);
        oe_a = 1'b0;
        tick(4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcd_mem_arb3.md
MCD_MEM_ARB3 -- requirements
Module: mcd_mem_arb3

Interface
REQ-001 SHALL have parameter: DELAY, 2, extra cycles that memory strobes stay asserted beyond the first (access length = DELAY+1 cycles, legal 1..7).
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have per requester x in {a,b,c}: oe_x  input  1  read request level.
REQ-005 SHALL have per requester: we_lo_x, we_hi_x  input  1 each  byte write request levels.
REQ-006 SHALL have per requester: addr_x  input  23  word address; din_x  input  16  write data.
REQ-007 SHALL have per requester: dout_x  output  16  registered read data; ack_x  output  1  one-cycle completion pulse.
REQ-008 SHALL have memory side: addr  output  23; din  output  16 (data to memory); dout  input  16 (data from memory).
REQ-009 SHALL have memory side: oe, we_lo, we_hi  output  1 each, registered strobes.

Function
REQ-010 Request of port x SHALL be req_x = oe_x | we_lo_x | we_hi_x; a rising edge (req_x high, registered previous value low) SHALL set pending_x.
REQ-011 An edge arriving while pending_x is already set SHALL merge into the single pending access.
REQ-012 An edge in the same cycle its port is granted SHALL be consumed by that grant and SHALL NOT leave pending set.
REQ-013 FSM states SHALL be IDLE, ACCESS, RECOVER.
REQ-014 In IDLE, if any port has pending or a same-cycle edge, the arbiter SHALL grant one port: register addr_x, din_x, oe_x, we_lo_x, we_hi_x onto the memory side, load counter = DELAY, clear pending_x, go to ACCESS.
REQ-015 Grant SHALL be round-robin: search starts at the port after the last granted (order a, b, c, a); after reset, last granted = c, so a wins first.
REQ-016 If write and read strobes are both set at grant, both SHALL be forwarded unchanged; the memory decides.
REQ-017 In ACCESS with counter nonzero, counter SHALL decrement and the memory-side outputs SHALL hold.
REQ-018 In ACCESS with counter zero: memory strobes SHALL drop to 0; if oe was set, dout SHALL be captured into dout_x of the granted port; ack_x SHALL pulse high the following cycle for exactly one cycle; go to RECOVER.
REQ-019 RECOVER SHALL last exactly one cycle with all strobes low, then go to IDLE.
REQ-020 Latency from an edge at an idle arbiter to ack_x SHALL be DELAY+2 cycles; back-to-back access period SHALL be DELAY+3 cycles.
REQ-021 dout_x of non-granted ports and of write accesses SHALL hold their previous value.
REQ-022 Requesters SHALL hold addr_x/din_x/strobes stable from edge until ack_x; the arbiter samples them only at grant.

Reset
REQ-023 On rst, immediately: oe, we_lo, we_hi, all ack_x = 0; addr, din, all dout_x = 0; all pending cleared; previous-request registers = 0; state = IDLE; counter = 0; last granted = c.
REQ-024 Reset mid-ACCESS SHALL abort the access with no ack; a request level still high after reset SHALL NOT be treated as a new edge until it falls and rises again.

Structure
REQ-025 A shared package mcd_arb_pkg SHALL hold the state enum, the port-index enum (PORT_A, PORT_B, PORT_C) and the DELAY default.
REQ-026 Edge detection plus pending latch SHALL be one sub-module, mcd_req_latch (inputs clk, rst, req, grant; output pend), instantiated three times.

Verification
REQ-027 Single read, DELAY=2: oe_a rises with addr_a=0x000100, memory returns 0x1234 -> oe high 3 cycles, ack_a at edge+4, dout_a=0x1234.
REQ-028 Simultaneous edges a, b, c after reset -> grant order a, b, c; acks 5 cycles apart; each port's dout holds its own data.
REQ-029 Byte write: we_hi_b only, din_b=0xAB00 -> we_hi high 3 cycles, we_lo never high, din=0xAB00, ack_b pulses, dout_b unchanged.
REQ-030 Port a re-requests (drop then raise) during its own ACCESS while c pends -> c served before a (round-robin), a served once afterward.
REQ-031 rst asserted in second ACCESS cycle with oe_a held high -> strobes drop immediately, no ack_a; after release no access until oe_a falls and rises.
